// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Single-outstanding instruction fetch stage. Requests the word at
//            Pc, holds it for the datapath until retired, then advances Pc
//            sequentially (Pc+4) or to a branch target.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   NextPcSrc    - 1 = next Pc is BrTarget, 0 = Pc+4 (sampled on retire)
//   BrTarget     - branch/jump target address
//   InstRetire   - datapath consumed the held instruction this cycle
//   ImemReq/Addr - instruction-memory read request and address
//   ImemAck/Data - memory response strobe and returned word
//   Inst/InstValid - held instruction and its valid flag
//   Pc/PcPlus4   - address of Inst and that address plus 4 (wrapping)
//   MisalignErr  - sticky misaligned branch target flag
// Configuration macro:
//   MISALIGN_TRAP_EN - when defined, a taken branch to a target with
//                      BrTarget[1:0]!=0 halts the unit and sets MisalignErr.
//                      When undefined, the low target bits are cleared.
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        NextPcSrc,
  input  logic [31:0] BrTarget,
  input  logic        InstRetire,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] ImemData,
  output logic [31:0] Inst,
  output logic        InstValid,
  output logic [31:0] Pc,
  output logic [31:0] PcPlus4,
  output logic        MisalignErr
);

  localparam logic [31:0] C_NOP_INST = 32'h00000013;

`ifdef MISALIGN_TRAP_EN
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;
`else
  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] w_pc_plus4;

  // Natural 32-bit overflow gives the required wrap from FFFFFFFC to 0.
  assign w_pc_plus4 = pc_q + 32'd4;

`ifdef MISALIGN_TRAP_EN
  logic err_q, err_d;
`else
  // Low target bits are discarded when no trap is built in.
  logic w_unused_br_lsb;
  assign w_unused_br_lsb = ^BrTarget[1:0];
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
`ifdef MISALIGN_TRAP_EN
    err_d   = err_q;
`endif
    case (state_q)
      ST_FETCH: begin
        if (ImemAck) begin
          inst_d  = ImemData;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Branch inputs only matter at the moment of retirement.
        if (InstRetire) begin
          if (NextPcSrc) begin
`ifdef MISALIGN_TRAP_EN
            if (BrTarget[1:0] != 2'b00) begin
              err_d   = 1'b1;
              state_d = ST_HALT;
            end else begin
              pc_d    = BrTarget;
              state_d = ST_FETCH;
            end
`else
            pc_d    = {BrTarget[31:2], 2'b00};
            state_d = ST_FETCH;
`endif
          end else begin
            pc_d    = w_pc_plus4;
            state_d = ST_FETCH;
          end
        end
      end
`ifdef MISALIGN_TRAP_EN
      ST_HALT: begin
        // Only reset leaves this state.
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_FETCH;
      end
`endif
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      inst_q  <= C_NOP_INST;
`ifdef MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
`ifdef MISALIGN_TRAP_EN
      err_q   <= err_d;
`endif
    end
  end

  // Request/valid are masked by rst so they read 0 for the whole reset
  // window, not only after the first reset edge.
  assign ImemReq   = !rst && (state_q == ST_FETCH);
  assign InstValid = !rst && (state_q == ST_HOLD);
  assign ImemAddr  = pc_q;
  assign Pc        = pc_q;
  assign PcPlus4   = w_pc_plus4;
  assign Inst      = inst_q;
`ifdef MISALIGN_TRAP_EN
  assign MisalignErr = err_q;
`else
  assign MisalignErr = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. An architectural model
//            (held instruction, Pc, halted flag) predicts every output on each
//            falling edge; directed vectors add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] C_NOP = 32'h00000013;

  logic        clk;
  logic        rst;
  logic        NextPcSrc;
  logic [31:0] BrTarget;
  logic        InstRetire;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck;
  logic [31:0] ImemData;
  logic [31:0] Inst;
  logic        InstValid;
  logic [31:0] Pc;
  logic [31:0] PcPlus4;
  logic        MisalignErr;

  int tests = 0;
  int fails = 0;

  fetch_unit #(.RESET_PC(32'h00000000)) dut (
    .clk        (clk),
    .rst        (rst),
    .NextPcSrc  (NextPcSrc),
    .BrTarget   (BrTarget),
    .InstRetire (InstRetire),
    .ImemReq    (ImemReq),
    .ImemAddr   (ImemAddr),
    .ImemAck    (ImemAck),
    .ImemData   (ImemData),
    .Inst       (Inst),
    .InstValid  (InstValid),
    .Pc         (Pc),
    .PcPlus4    (PcPlus4),
    .MisalignErr(MisalignErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: a distinct word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  assign ImemData = mem_word(ImemAddr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- architectural model ----------------
  logic        m_known = 1'b0;
  logic        m_have;    // an instruction is held for the datapath
  logic        m_halt;
  logic        m_err;
  logic [31:0] m_pc;
  logic [31:0] m_inst;

  always @(posedge clk) begin
    if (rst) begin
      m_known <= 1'b1;
      m_have  <= 1'b0;
      m_halt  <= 1'b0;
      m_err   <= 1'b0;
      m_pc    <= 32'h00000000;
      m_inst  <= C_NOP;
    end else if (m_known && !m_halt) begin
      if (!m_have) begin
        if (ImemAck) begin
          m_inst <= ImemData;
          m_have <= 1'b1;
        end
      end else if (InstRetire) begin
        if (!NextPcSrc) begin
          m_pc   <= m_pc + 32'd4;
          m_have <= 1'b0;
        end else if (BrTarget % 4 == 0) begin
          m_pc   <= BrTarget;
          m_have <= 1'b0;
        end else begin
`ifdef MISALIGN_TRAP_EN
          m_halt <= 1'b1;
          m_err  <= 1'b1;
          m_have <= 1'b0;
`else
          m_pc   <= BrTarget - (BrTarget % 4);
          m_have <= 1'b0;
`endif
        end
      end
    end
  end

  // Compare every cycle once the model has seen reset.
  always @(negedge clk) begin
    if (m_known) begin
      check("m_req",   {31'd0, ImemReq},     {31'd0, !rst && !m_halt && !m_have});
      check("m_valid", {31'd0, InstValid},   {31'd0, !rst && !m_halt && m_have});
      check("m_addr",  ImemAddr,             m_pc);
      check("m_pc",    Pc,                   m_pc);
      check("m_pc4",   PcPlus4,              m_pc + 32'd4);
      check("m_inst",  Inst,                 m_inst);
      check("m_err",   {31'd0, MisalignErr}, {31'd0, m_err});
    end
  end

  // Drive inputs, then advance one clock; returns 1ns after the edge.
  task automatic step(input logic r, input logic ack, input logic ret,
                      input logic nps, input logic [31:0] bt);
    rst        = r;
    ImemAck    = ack;
    InstRetire = ret;
    NextPcSrc  = nps;
    BrTarget   = bt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ImemAck = 1'b0; InstRetire = 1'b0; NextPcSrc = 1'b0; BrTarget = 32'h0;

    // Reset state.
    step(1, 1, 1, 1, 32'h80);
    step(1, 1, 1, 1, 32'h80);
    check("rst_req",   {31'd0, ImemReq},     32'd0);
    check("rst_valid", {31'd0, InstValid},   32'd0);
    check("rst_pc",    Pc,                   32'h00000000);
    check("rst_inst",  Inst,                 32'h00000013);
    check("rst_err",   {31'd0, MisalignErr}, 32'd0);

    // First request right after reset release.
    step(0, 0, 0, 0, 32'h0);
    check("first_req",  {31'd0, ImemReq}, 32'd1);
    check("first_addr", ImemAddr,         32'h00000000);

    // Back-to-back: ack and retire every cycle -> 0, 4, 8 with valid toggling.
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, 0, 32'h0);
      check("tput_valid", {31'd0, InstValid}, (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i == 1) check("tput_addr4", ImemAddr, 32'h00000004);
      if (i == 3) check("tput_addr8", ImemAddr, 32'h00000008);
    end

    // Walk to Pc=0x10 then take a branch to 0x40.
    step(0, 1, 0, 0, 32'h0);      // HOLD @8
    step(0, 0, 1, 0, 32'h0);      // FETCH @C
    step(0, 1, 0, 0, 32'h0);      // HOLD @C
    step(0, 0, 1, 0, 32'h0);      // FETCH @10
    step(0, 1, 0, 0, 32'h0);      // HOLD @10
    check("pc_10", Pc, 32'h00000010);
    step(0, 0, 1, 1, 32'h40);
    check("br_addr", ImemAddr, 32'h00000040);
    check("br_pc4",  PcPlus4,  32'h00000044);

    // Slow ack, then stalled retire with NextPcSrc wiggling.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, i[0], 32'h100);
      check("wait_addr", ImemAddr, 32'h00000040);
    end
    step(0, 1, 0, 0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, ~i[0], 32'h100);
      check("stall_pc",   Pc,   32'h00000040);
      check("stall_inst", Inst, mem_word(32'h00000040));
    end
    step(0, 0, 1, 0, 32'h100);
    check("stall_next", ImemAddr, 32'h00000044);

    // Wrap of Pc+4.
    step(0, 1, 0, 0, 32'h0);
    step(0, 0, 1, 1, 32'hFFFFFFFC);
    check("wrap_pc4", PcPlus4, 32'h00000000);
    step(0, 1, 0, 0, 32'h0);
    step(0, 0, 1, 0, 32'h0);
    check("wrap_addr", ImemAddr, 32'h00000000);

    // Misaligned branch target.
    step(0, 1, 0, 0, 32'h0);
    step(0, 0, 1, 1, 32'h42);
`ifdef MISALIGN_TRAP_EN
    check("mis_err", {31'd0, MisalignErr}, 32'd1);
    check("mis_req", {31'd0, ImemReq},     32'd0);
    check("mis_pc",  Pc,                   32'h00000000);
    step(0, 1, 1, 0, 32'h0);
    step(0, 1, 1, 1, 32'h8);
    check("mis_stuck_pc",  Pc,                   32'h00000000);
    check("mis_stuck_err", {31'd0, MisalignErr}, 32'd1);
    step(1, 0, 0, 0, 32'h0);
    check("mis_rst_err", {31'd0, MisalignErr}, 32'd0);
    step(0, 0, 0, 0, 32'h0);
`else
    check("mis_addr", ImemAddr,             32'h00000040);
    check("mis_err",  {31'd0, MisalignErr}, 32'd0);
`endif

    // Reset overrides a pending ack in FETCH.
    step(1, 1, 0, 0, 32'h0);
    check("rst_ack_valid", {31'd0, InstValid}, 32'd0);
    check("rst_ack_inst",  Inst,               32'h00000013);
    step(0, 0, 0, 0, 32'h0);
    check("rst_ack_req",   {31'd0, ImemReq},   32'd1);

    // Reset overrides a retire in HOLD.
    step(0, 1, 0, 0, 32'h0);
    step(0, 0, 1, 0, 32'h0);
    step(0, 1, 0, 0, 32'h0);
    check("hold_pc4", Pc, 32'h00000004);
    step(1, 0, 1, 1, 32'h200);
    check("hold_rst_pc",   Pc,   32'h00000000);
    check("hold_rst_inst", Inst, 32'h00000013);
    step(0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
